bus_drive_decoder: RTL and testbench

Registered 5-to-32 bus-source decoder that turns a 5-bit source code into a one-hot drive enable for the shared datapath bus. It is the inverse of the bus-select encoder: it converts a source code back into per-register/unit tri-state enables. It guarantees break-before-make, meaning at least one all-zero cycle between any two drivers. It also enforces a minimum drive time and runs a request/release handshake with the control unit.

---
 rtl/bus_drive_decoder_if.sv | 45 ++++
 rtl/bus_drive_decoder.sv | 166 ++++++++++++++++
 tb/tb_bus_drive_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_drive_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_drive_decoder_if
// Description : Handshake and drive-enable bundle between the control unit
//               (master) and the bus drive decoder (slave).
//   req         : request to drive src_code (master -> slave)
//   src_code    : 5-bit bus source code, 31 = none (master -> slave)
//   release_req : request to end the current drive (master -> slave)
//   busy        : decoder is committed to a request (slave -> master)
//   grant       : one-cycle pulse on first driving cycle (slave -> master)
//   drive_en    : one-hot tri-state drive enable, or zero (slave -> master)
//   err         : one-cycle pulse for an invalid request code (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_drive_decoder_if;
  logic        req;
  logic [4:0]  src_code;
  // "release" is a reserved word, hence the _req suffix.
  logic        release_req;
  logic        busy;
  logic        grant;
  logic [31:0] drive_en;
  logic        err;

  modport master (
    output req,
    output src_code,
    output release_req,
    input  busy,
    input  grant,
    input  drive_en,
    input  err
  );

  modport slave (
    input  req,
    input  src_code,
    input  release_req,
    output busy,
    output grant,
    output drive_en,
    output err
  );
endinterface
`default_nettype wire

// File: rtl/bus_drive_decoder.sv
`default_nettype none
// ============================================================================
// Module      : bus_drive_decoder
// Description : Registered 5-to-32 bus-source decoder. Turns an accepted
//               source code into a one-hot drive enable for the shared bus,
//               with break-before-make dead cycles, a minimum drive time and a
//               request/release handshake.
// Ports       :
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : bus_drive_decoder_if.slave (req, src_code, release_req,
//           busy, grant, drive_en, err)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_drive_decoder #(
  parameter int NUM_SOURCES = 24,  // valid codes are 0..NUM_SOURCES-1 (1..31)
  parameter int GAP_CYCLES  = 1,   // dead cycles before a new drive (>=1)
  parameter int MIN_HOLD    = 1    // minimum drive cycles (>=1)
) (
  input  wire                 clock,
  input  wire                 clear,
  bus_drive_decoder_if.slave  bus
);

  localparam int c_GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int c_HOLD_W = $clog2(MIN_HOLD + 1);

  localparam logic [c_GAP_W-1:0]  c_GAP_LOAD  = c_GAP_W'(GAP_CYCLES);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(MIN_HOLD);
  localparam logic [5:0]          c_NUM_SRC   = 6'(NUM_SOURCES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                r_state,   w_state;
  logic [4:0]            r_code,    w_code;
  logic [c_GAP_W-1:0]    r_gap,     w_gap;
  logic [c_HOLD_W-1:0]   r_hold,    w_hold;
  logic                  r_pending, w_pending;
  logic [31:0]           r_drive,   w_drive;
  logic                  r_busy,    w_busy;
  logic                  r_grant,   w_grant;
  logic                  r_err,     w_err;

  logic                  w_code_ok;
  logic [c_HOLD_W-1:0]   w_hold_dec;

  // Code 31 ("none") is always >= NUM_SOURCES, so it is rejected here too.
  assign w_code_ok  = ({1'b0, bus.src_code} < c_NUM_SRC);

  // Saturating decrement: the hold counter parks at zero once satisfied.
  assign w_hold_dec = (r_hold == '0) ? '0 : (r_hold - c_HOLD_W'(1));

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= ST_IDLE;
      r_code    <= '0;
      r_gap     <= '0;
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_drive   <= '0;
      r_busy    <= 1'b0;
      r_grant   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_code    <= w_code;
      r_gap     <= w_gap;
      r_hold    <= w_hold;
      r_pending <= w_pending;
      r_drive   <= w_drive;
      r_busy    <= w_busy;
      r_grant   <= w_grant;
      r_err     <= w_err;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state   = r_state;
    w_code    = r_code;
    w_gap     = r_gap;
    w_hold    = r_hold;
    w_pending = r_pending;
    w_drive   = r_drive;
    w_busy    = r_busy;
    w_grant   = 1'b0;
    w_err     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // release_req has no meaning here and is ignored.
        if (bus.req) begin
          if (w_code_ok) begin
            w_code  = bus.src_code;
            w_gap   = c_GAP_LOAD;
            w_state = ST_GAP;
            w_busy  = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (bus.release_req) begin
          // Abort before anything has been driven: no grant is issued.
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_gap   = '0;
        end else if (r_gap <= c_GAP_W'(1)) begin
          // This edge takes the gap counter to zero: start driving now so
          // the driver appears GAP_CYCLES edges after acceptance.
          w_state   = ST_DRIVE;
          w_gap     = '0;
          w_drive   = 32'd1 << r_code;
          w_grant   = 1'b1;
          w_hold    = c_HOLD_LOAD;
          w_pending = 1'b0;
        end else begin
          w_gap = r_gap - c_GAP_W'(1);
        end
      end

      ST_DRIVE: begin
        // Exit on the edge where the hold counter reaches (or sits at) zero,
        // so the bus is driven for at least MIN_HOLD cycles. A pending
        // release takes priority over any req presented at the same time.
        if ((w_hold_dec == '0) && (bus.release_req || r_pending)) begin
          w_state   = ST_IDLE;
          w_drive   = '0;
          w_busy    = 1'b0;
          w_hold    = '0;
          w_pending = 1'b0;
        end else begin
          w_hold    = w_hold_dec;
          w_pending = r_pending | bus.release_req;
        end
      end

      default: begin
        w_state   = ST_IDLE;
        w_drive   = '0;
        w_busy    = 1'b0;
        w_gap     = '0;
        w_hold    = '0;
        w_pending = 1'b0;
      end
    endcase
  end

  assign bus.busy     = r_busy;
  assign bus.grant    = r_grant;
  assign bus.drive_en = r_drive;
  assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_drive_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_drive_decoder
// Description : Directed self-checking bench for bus_drive_decoder. Three
//               instances cover the default timing, MIN_HOLD=4 and
//               GAP_CYCLES=3. Inputs change on the falling edge, outputs are
//               compared on the falling edge after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_drive_decoder;

  logic clock;
  logic clear;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  bus_drive_decoder_if ifa ();
  bus_drive_decoder_if ifb ();
  bus_drive_decoder_if ifc ();

  bus_drive_decoder #(.NUM_SOURCES(24), .GAP_CYCLES(1), .MIN_HOLD(1)) dut_a (
    .clock (clock),
    .clear (clear),
    .bus   (ifa)
  );

  bus_drive_decoder #(.NUM_SOURCES(24), .GAP_CYCLES(1), .MIN_HOLD(4)) dut_b (
    .clock (clock),
    .clear (clear),
    .bus   (ifb)
  );

  bus_drive_decoder #(.NUM_SOURCES(24), .GAP_CYCLES(3), .MIN_HOLD(1)) dut_c (
    .clock (clock),
    .clear (clear),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b0;
    ifa.req = 1'b0; ifa.src_code = 5'd0; ifa.release_req = 1'b0;
    ifb.req = 1'b0; ifb.src_code = 5'd0; ifb.release_req = 1'b0;
    ifc.req = 1'b0; ifc.src_code = 5'd0; ifc.release_req = 1'b0;

    // ---------------- reset state ----------------
    tick; tick;
    check("rst_drive", ifa.drive_en, 32'h0);
    check("rst_busy",  {31'd0, ifa.busy},  32'd0);
    check("rst_grant", {31'd0, ifa.grant}, 32'd0);
    check("rst_err",   {31'd0, ifa.err},   32'd0);
    clear = 1'b1;
    tick;

    // ---------------- code 5, GAP=1, HOLD=1 ----------------
    ifa.src_code = 5'd5; ifa.req = 1'b1;
    tick;                                   // accepted
    check("c5_busy_acc",  {31'd0, ifa.busy},  32'd1);
    check("c5_drive_gap", ifa.drive_en, 32'h0);
    check("c5_grant_gap", {31'd0, ifa.grant}, 32'd0);
    ifa.req = 1'b0; ifa.src_code = 5'd9;    // late change must not matter
    tick;
    check("c5_drive",  ifa.drive_en, 32'h0000_0020);
    check("c5_grant",  {31'd0, ifa.grant}, 32'd1);
    check("c5_busy",   {31'd0, ifa.busy},  32'd1);
    tick;
    check("c5_drive_hold", ifa.drive_en, 32'h0000_0020);
    check("c5_grant_once", {31'd0, ifa.grant}, 32'd0);
    tick;
    check("c5_drive_stay", ifa.drive_en, 32'h0000_0020);
    ifa.release_req = 1'b1;
    tick;
    check("c5_rel_drive", ifa.drive_en, 32'h0);
    check("c5_rel_busy",  {31'd0, ifa.busy}, 32'd0);
    ifa.release_req = 1'b0;

    // ---------------- invalid codes 24 and 31 ----------------
    ifa.src_code = 5'd24; ifa.req = 1'b1;
    tick;
    check("e24_err",   {31'd0, ifa.err},  32'd1);
    check("e24_busy",  {31'd0, ifa.busy}, 32'd0);
    check("e24_drive", ifa.drive_en, 32'h0);
    ifa.src_code = 5'd31;
    tick;
    check("e31_err",   {31'd0, ifa.err},  32'd1);
    check("e31_busy",  {31'd0, ifa.busy}, 32'd0);
    ifa.req = 1'b0;
    tick;
    check("e_err_clr", {31'd0, ifa.err},  32'd0);
    check("e_drive",   ifa.drive_en, 32'h0);

    // ---------------- code 3 then code 17 back to back ----------------
    ifa.src_code = 5'd3; ifa.req = 1'b1;
    tick;
    ifa.req = 1'b0;
    tick;
    check("b2b_drive3", ifa.drive_en, 32'h0000_0008);
    ifa.release_req = 1'b1;
    tick;                                   // release, hold met
    check("b2b_gap1", ifa.drive_en, 32'h0);
    check("b2b_busy0", {31'd0, ifa.busy}, 32'd0);
    ifa.release_req = 1'b0; ifa.src_code = 5'd17; ifa.req = 1'b1;
    tick;                                   // new req accepted
    check("b2b_gap2", ifa.drive_en, 32'h0);
    check("b2b_busy1", {31'd0, ifa.busy}, 32'd1);
    ifa.req = 1'b0;
    tick;
    check("b2b_drive17", ifa.drive_en, 32'h0002_0000);
    check("b2b_grant17", {31'd0, ifa.grant}, 32'd1);
    // release and req together: release wins, req is dropped
    ifa.release_req = 1'b1; ifa.req = 1'b1; ifa.src_code = 5'd2;
    tick;
    check("rw_drive", ifa.drive_en, 32'h0);
    check("rw_busy",  {31'd0, ifa.busy}, 32'd0);
    ifa.release_req = 1'b0; ifa.req = 1'b0;
    tick;
    check("rw_noqueue_busy",  {31'd0, ifa.busy}, 32'd0);
    tick;
    check("rw_noqueue_drive", ifa.drive_en, 32'h0);

    // ---------------- MIN_HOLD=4 on code 0 ----------------
    ifb.src_code = 5'd0; ifb.req = 1'b1;
    tick;
    ifb.req = 1'b0;
    tick;
    check("h4_drive_c1", ifb.drive_en, 32'h1);
    check("h4_grant",    {31'd0, ifb.grant}, 32'd1);
    ifb.release_req = 1'b1;                 // one cycle after grant
    tick;
    check("h4_drive_c2", ifb.drive_en, 32'h1);
    ifb.release_req = 1'b0;                 // pending must remember it
    tick;
    check("h4_drive_c3", ifb.drive_en, 32'h1);
    tick;
    check("h4_drive_c4", ifb.drive_en, 32'h1);
    check("h4_busy_c4",  {31'd0, ifb.busy}, 32'd1);
    tick;
    check("h4_drive_end", ifb.drive_en, 32'h0);
    check("h4_busy_end",  {31'd0, ifb.busy}, 32'd0);

    // ---------------- GAP=3: full latency, then abort in GAP ----------------
    ifc.src_code = 5'd7; ifc.req = 1'b1;
    tick;                                   // accepted
    ifc.req = 1'b0;
    tick;
    check("g3_drive_t1", ifc.drive_en, 32'h0);
    tick;
    check("g3_drive_t2", ifc.drive_en, 32'h0);
    tick;
    check("g3_drive_t3", ifc.drive_en, 32'h0000_0080);
    check("g3_grant_t3", {31'd0, ifc.grant}, 32'd1);
    ifc.release_req = 1'b1;
    tick;
    check("g3_rel_drive", ifc.drive_en, 32'h0);
    ifc.release_req = 1'b0;
    ifc.src_code = 5'd7; ifc.req = 1'b1;
    tick;                                   // accepted
    ifc.req = 1'b0;
    tick;
    check("ab_busy_gap", {31'd0, ifc.busy}, 32'd1);
    ifc.release_req = 1'b1;
    tick;
    check("ab_busy",  {31'd0, ifc.busy},  32'd0);
    check("ab_grant", {31'd0, ifc.grant}, 32'd0);
    check("ab_drive", ifc.drive_en, 32'h0);
    ifc.release_req = 1'b0;
    tick; tick;
    check("ab_no_grant", {31'd0, ifc.grant}, 32'd0);
    check("ab_no_drive", ifc.drive_en, 32'h0);

    // ---------------- asynchronous clear mid-drive, code 23 ----------------
    ifa.src_code = 5'd23; ifa.req = 1'b1;
    tick;
    ifa.req = 1'b0;
    tick;
    check("clr_pre_drive", ifa.drive_en, 32'h0080_0000);
    #2 clear = 1'b0;
    #1;
    check("clr_async_drive", ifa.drive_en, 32'h0);
    check("clr_async_busy",  {31'd0, ifa.busy}, 32'd0);
    tick;
    clear = 1'b1;
    tick; tick;
    check("clr_after_drive", ifa.drive_en, 32'h0);
    check("clr_after_busy",  {31'd0, ifa.busy},  32'd0);
    check("clr_after_grant", {31'd0, ifa.grant}, 32'd0);
    check("clr_after_err",   {31'd0, ifa.err},   32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
